// File: rtl/rr_stream_select_2to1_pkg.sv
// rr_stream_select_2to1_pkg: shared arbiter state, source encodings and default beat width
package rr_stream_select_2to1_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, LOCK_A = 2'd1, LOCK_B = 2'd2} state_t;
endpackage

// File: rtl/rr_stream_select_2to1_stream_out_reg.sv
// stream_out_reg: one-entry registered output stage holding data/last/source until drained
// Ports: clk, reset (async, active-high); load/in_data/in_last/in_sel capture a beat;
// load_en tells the producer the register can take a beat this cycle;
// dout_valid/dout_ready/dout_data/dout_last/sel form the downstream side.
module stream_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             load_en,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout_data,
  output logic             dout_last,
  output logic             sel
);
  // Loading while the old beat drains gives one beat per cycle with no bubble.
  assign load_en = !dout_valid || dout_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_last  <= 1'b0;
      sel        <= 1'b0;
    end else if (load && load_en) begin
      dout_valid <= 1'b1;
      dout_data  <= in_data;
      dout_last  <= in_last;
      sel        <= in_sel;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
endmodule

// File: rtl/rr_stream_select_2to1.sv
// rr_stream_select_2to1: round-robin packet arbiter for two valid/ready streams driving the mux select
// Ports: clk, reset (async, active-high); a_*/b_* input streams (valid/ready/data/last);
// dout_* registered output stream; sel = source of the beat in the output register (0=A, 1=B).
module rr_stream_select_2to1
  import rr_stream_select_2to1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             sel,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout_data,
  output logic             dout_last
);
  state_t           state;
  logic             prio;
  logic             gnt;
  logic             gnt_valid;
  logic             load_en;
  logic             acc;
  logic             in_last;
  logic [WIDTH-1:0] in_data;
  // A locked packet keeps its grant through bubbles; ties in IDLE go to prio.
  always_comb begin
    gnt = state == LOCK_B ? SRC_B :
          state == LOCK_A ? SRC_A :
          (a_valid && b_valid) ? prio :
          (b_valid ? SRC_B : SRC_A);
    gnt_valid = !reset && (state != IDLE || a_valid || b_valid);
  end
  assign a_ready = gnt_valid && load_en && gnt == SRC_A;
  assign b_ready = gnt_valid && load_en && gnt == SRC_B;
  assign acc     = (a_valid && a_ready) || (b_valid && b_ready);
  // Only the granted stream reaches the register, and only on its handshake.
  assign in_data = gnt == SRC_B ? b_data : a_data;
  assign in_last = gnt == SRC_B ? b_last : a_last;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      prio  <= SRC_A;
    end else if (acc) begin
      state <= in_last ? IDLE : (gnt == SRC_B ? LOCK_B : LOCK_A);
      if (in_last) prio <= ~gnt;
    end
  stream_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk        (clk),
    .reset      (reset),
    .load       (acc),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_sel     (gnt),
    .load_en    (load_en),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_last  (dout_last),
    .sel        (sel)
  );
endmodule

// File: tb/tb_rr_stream_select_2to1.sv
// tb_rr_stream_select_2to1: scenario tasks plus an output scoreboard for the round-robin stream select
module tb_rr_stream_select_2to1;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0, dout_ready = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, sel, dout_valid, dout_last;
  logic [7:0] dout_data;
  int         passed = 0, total = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_beat;

  rr_stream_select_2to1 #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
    .sel(sel), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_last(dout_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

  // Every beat consumed downstream must match the next expected {sel,last,data}.
  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected got sel=%b last=%b data=%h exp none", sel, dout_last, dout_data);
      end else begin
        exp_beat = sb.pop_front();
        if ({sel, dout_last, dout_data} !== exp_beat)
          $display("FAIL sb_beat got sel=%b last=%b data=%h exp sel=%b last=%b data=%h",
                   sel, dout_last, dout_data, exp_beat[9], exp_beat[8], exp_beat[7:0]);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    total++;
    if (sb.size() != 0) $display("FAIL %s_drain got %0d pending exp 0", name, sb.size()); else passed++;
  endtask

  task automatic test_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hC1; b_data = 8'hC2; a_last = 1'b1; b_last = 1'b1; dout_ready = 1'b1;
    tick(); tick();
    total++; if (dout_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", dout_valid); else passed++;
    total++; if (dout_data !== 8'h00) $display("FAIL rst_data got %h exp 00", dout_data); else passed++;
    total++; if (dout_last !== 1'b0) $display("FAIL rst_last got %b exp 0", dout_last); else passed++;
    total++; if (sel !== 1'b0) $display("FAIL rst_sel got %b exp 0", sel); else passed++;
    total++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL rst_ready got %b exp 00", {a_ready, b_ready}); else passed++;
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_idle_single();
    b_valid = 1'b1; b_data = 8'h7E; b_last = 1'b1; dout_ready = 1'b1;
    sb.push_back({1'b1, 1'b1, 8'h7E});
    #1;
    total++; if ({a_ready, b_ready} !== 2'b01) $display("FAIL single_ready got %b exp 01", {a_ready, b_ready}); else passed++;
    tick();
    b_valid = 1'b0;
    total++; if ({dout_valid, sel, dout_data} !== {2'b11, 8'h7E}) $display("FAIL single_out got v=%b sel=%b d=%h exp v=1 sel=1 d=7e", dout_valid, sel, dout_data); else passed++;
    tick();
    total++; if (dout_valid !== 1'b0) $display("FAIL single_drain_valid got %b exp 0", dout_valid); else passed++;
    test_drain("single");
  endtask

  task automatic test_tie_fairness();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22; a_last = 1'b1; b_last = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back(i % 2 == 0 ? {1'b0, 1'b1, 8'h11} : {1'b1, 1'b1, 8'h22});
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({a_ready, b_ready} !== (i % 2 == 0 ? 2'b10 : 2'b01)) $display("FAIL tie_ready%0d got %b exp %b", i, {a_ready, b_ready}, (i % 2 == 0 ? 2'b10 : 2'b01)); else passed++;
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    test_drain("tie");
  endtask

  task automatic test_packet_lock();
    logic [7:0] beats[3] = '{8'hA0, 8'hA1, 8'hA2};
    a_valid = 1'b1; b_valid = 1'b1; b_data = 8'h33; b_last = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back({1'b0, i == 2, beats[i]});
    sb.push_back({1'b1, 1'b1, 8'h33});
    for (int i = 0; i < 3; i++) begin
      a_data = beats[i]; a_last = (i == 2);
      #1;
      total++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL lock_ready%0d got %b exp 10", i, {a_ready, b_ready}); else passed++;
      tick();
    end
    a_valid = 1'b0;
    #1;
    total++; if ({a_ready, b_ready} !== 2'b01) $display("FAIL lock_b_ready got %b exp 01", {a_ready, b_ready}); else passed++;
    tick();
    b_valid = 1'b0;
    total++; if ({dout_valid, sel, dout_data} !== {2'b11, 8'h33}) $display("FAIL lock_b_out got v=%b sel=%b d=%h exp v=1 sel=1 d=33", dout_valid, sel, dout_data); else passed++;
    tick();
    test_drain("lock");
  endtask

  task automatic test_backpressure();
    a_valid = 1'b1; a_data = 8'h5A; a_last = 1'b1; dout_ready = 1'b1;
    sb.push_back({1'b0, 1'b1, 8'h5A});
    sb.push_back({1'b0, 1'b1, 8'h6B});
    tick();
    a_data = 8'h6B; dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({dout_valid, dout_data, a_ready, b_ready} !== {1'b1, 8'h5A, 2'b00})
        $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b%b exp v=1 d=5a rdy=00", i, dout_valid, dout_data, a_ready, b_ready);
      else passed++;
      tick();
    end
    dout_ready = 1'b1;
    #1;
    total++; if (a_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", a_ready); else passed++;
    tick();
    a_valid = 1'b0;
    total++; if ({dout_valid, dout_data} !== {1'b1, 8'h6B}) $display("FAIL bp_no_bubble got v=%b d=%h exp v=1 d=6b", dout_valid, dout_data); else passed++;
    tick();
    test_drain("bp");
  endtask

  task automatic test_bubble();
    dout_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'hA0; a_last = 1'b0; b_valid = 1'b0;
    sb.push_back({1'b0, 1'b0, 8'hA0});
    sb.push_back({1'b0, 1'b1, 8'hA1});
    sb.push_back({1'b1, 1'b1, 8'h44});
    #1;
    total++; if (a_ready !== 1'b1) $display("FAIL bub_a0_ready got %b exp 1", a_ready); else passed++;
    tick();
    a_valid = 1'b0; a_data = 8'hFF; b_valid = 1'b1; b_data = 8'h44; b_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (b_ready !== 1'b0) $display("FAIL bub_b_ready%0d got %b exp 0", i, b_ready); else passed++;
      if (i == 1) begin
        total++; if (dout_valid !== 1'b0) $display("FAIL bub_gap_valid got %b exp 0", dout_valid); else passed++;
      end
      tick();
    end
    a_valid = 1'b1; a_data = 8'hA1; a_last = 1'b1;
    #1;
    total++; if ({dout_valid, a_ready, b_ready} !== 3'b010) $display("FAIL bub_resume got v=%b rdy=%b%b exp v=0 rdy=10", dout_valid, a_ready, b_ready); else passed++;
    tick();
    a_valid = 1'b0;
    #1;
    total++; if ({dout_data, b_ready} !== {8'hA1, 1'b1}) $display("FAIL bub_a1_then_b got d=%h b_ready=%b exp d=a1 b_ready=1", dout_data, b_ready); else passed++;
    tick();
    b_valid = 1'b0;
    tick();
    test_drain("bubble");
  endtask

  task automatic test_reset_mid_traffic();
    b_valid = 1'b1; b_data = 8'h55; b_last = 1'b0; a_valid = 1'b0; dout_ready = 1'b0;
    #1;
    total++; if (b_ready !== 1'b1) $display("FAIL rmid_b_ready got %b exp 1", b_ready); else passed++;
    tick();
    a_valid = 1'b1; a_data = 8'h66; a_last = 1'b1;
    total++; if ({dout_valid, sel, dout_data} !== {2'b11, 8'h55}) $display("FAIL rmid_locked got v=%b sel=%b d=%h exp v=1 sel=1 d=55", dout_valid, sel, dout_data); else passed++;
    #1 reset = 1'b1;
    #1;
    total++; if ({dout_valid, sel, a_ready, b_ready} !== 4'b0000) $display("FAIL rmid_async got v=%b sel=%b rdy=%b%b exp 0 0 00", dout_valid, sel, a_ready, b_ready); else passed++;
    tick();
    reset = 1'b0;
    b_data = 8'h77; b_last = 1'b1; dout_ready = 1'b1;
    sb.push_back({1'b0, 1'b1, 8'h66});
    sb.push_back({1'b1, 1'b1, 8'h77});
    #1;
    total++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL rmid_tie_a got %b exp 10", {a_ready, b_ready}); else passed++;
    tick();
    a_valid = 1'b0;
    #1;
    total++; if ({a_ready, b_ready} !== 2'b01) $display("FAIL rmid_then_b got %b exp 01", {a_ready, b_ready}); else passed++;
    tick();
    b_valid = 1'b0;
    tick();
    test_drain("rmid");
  endtask

  initial begin
    test_reset();
    test_idle_single();
    test_tie_fairness();
    test_packet_lock();
    test_backpressure();
    test_bubble();
    test_reset_mid_traffic();
    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
